i2c_word_tx: RTL and testbench

- I2C master transmitter that sends one 16-bit configuration word to a fixed 7-bit slave address, as a single write transaction.
- Consumer end of the config-table path: the ROM reader presents a 16-bit word, and this block shifts it onto the bus.
- Target is the audio codec control port: 16-bit word = 7-bit register address plus 9-bit data.
- One transaction per accepted start; reports completion and slave NACK.

---
 rtl/i2c_word_tx.sv | 154 +++++++++++++++
 tb/tb_i2c_word_tx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_word_tx.sv
// rtl/i2c_word_tx.sv - I2C master that writes one 16-bit word to a fixed 7-bit slave address
module i2c_word_tx #(
  parameter int unsigned CLK_DIV  = 125,
  parameter logic [6:0]  DEV_ADDR = 7'h1A
) (
  input  logic        clk50,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] data,
  output logic        busy,
  output logic        done,
  output logic        ack_err,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        sda_in
);

  localparam int unsigned   CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] QMAX = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_ACK,
    S_STOP,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    quarter_q, quarter_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [23:0]   shift_q, shift_d;
  logic          ack_err_q, ack_err_d;
  logic          scl_oe_q, scl_oe_d;
  logic          sda_oe_q, sda_oe_d;
  logic          tick;
  logic          phase_end;

  // Next-state, quarter timing and bus-level decode for the current quarter
  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    quarter_d = quarter_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    shift_d   = shift_q;
    ack_err_d = ack_err_q;
    scl_oe_d  = 1'b0;
    sda_oe_d  = 1'b0;
    tick      = (qcnt_q == QMAX);
    phase_end = tick && (quarter_q == 2'd3);

    if (state_q != S_IDLE && state_q != S_DONE) begin
      qcnt_d = tick ? '0 : qcnt_q + 1'b1;
      if (tick) begin
        quarter_d = quarter_q + 2'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_START;
          shift_d   = {DEV_ADDR, 1'b0, data};
          ack_err_d = 1'b0;
          qcnt_d    = '0;
          quarter_d = 2'd0;
          bit_d     = 3'd0;
          byte_d    = 2'd0;
        end
      end
      S_START: begin
        sda_oe_d = quarter_q[1];
        if (phase_end) begin
          state_d = S_BIT;
        end
      end
      S_BIT: begin
        scl_oe_d = ~quarter_q[1];
        sda_oe_d = ~shift_q[23];
        if (phase_end) begin
          shift_d = {shift_q[22:0], 1'b0};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_ACK;
          end
        end
      end
      S_ACK: begin
        scl_oe_d = ~quarter_q[1];
        if (tick && quarter_q == 2'd2 && sda_in) begin
          ack_err_d = 1'b1;
        end
        if (phase_end) begin
          // ack_err_q can only have been set by this slot, since it clears on acceptance
          if (ack_err_q || byte_q == 2'd2) begin
            state_d = S_STOP;
          end else begin
            state_d = S_BIT;
            byte_d  = byte_q + 2'd1;
          end
        end
      end
      S_STOP: begin
        scl_oe_d = (quarter_q == 2'd0);
        sda_oe_d = ~quarter_q[1];
        if (phase_end) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; bus drivers are registered so SCL/SDA never glitch on decode
  always_ff @(posedge clk50) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      qcnt_q    <= '0;
      quarter_q <= 2'd0;
      bit_q     <= 3'd0;
      byte_q    <= 2'd0;
      shift_q   <= 24'd0;
      ack_err_q <= 1'b0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      quarter_q <= quarter_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      shift_q   <= shift_d;
      ack_err_q <= ack_err_d;
      scl_oe_q  <= scl_oe_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

  assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done    = (state_q == S_DONE);
  assign ack_err = ack_err_q;
  assign scl_oe  = scl_oe_q;
  assign sda_oe  = sda_oe_q;

endmodule

// File: tb/tb_i2c_word_tx.sv
// tb/tb_i2c_word_tx.sv - randomized self-checking bench for i2c_word_tx with an I2C slave bus model
module tb_i2c_word_tx;

  localparam int unsigned CLK_DIV = 2;

  logic        clk50 = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] data;
  logic        busy, done, ack_err, scl_oe, sda_oe, sda_in;

  logic        pull = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          acc = 0;
  int          done_cnt = 0;
  int          starts = 0;
  int          stops = 0;
  int          nbits = 0;
  int          fbytes = 0;
  int          nack_byte = 3;
  logic [7:0]  cur = 8'h00;
  logic [7:0]  seen[$];
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;
  logic        m_scl, m_sda;

  i2c_word_tx #(.CLK_DIV(CLK_DIV), .DEV_ADDR(7'h1A)) dut (
    .clk50  (clk50),
    .reset_n(reset_n),
    .start  (start),
    .data   (data),
    .busy   (busy),
    .done   (done),
    .ack_err(ack_err),
    .scl_oe (scl_oe),
    .sda_oe (sda_oe),
    .sda_in (sda_in)
  );

  always #10 clk50 = ~clk50;

  // open-drain wired-AND of master and slave
  assign sda_in = ~(sda_oe | pull);

  always @(posedge clk50) cyc <= cyc + 1;

  // slave model: decodes START/STOP/bytes and ACKs every byte except nack_byte
  always @(negedge clk50) begin
    m_scl = ~scl_oe;
    m_sda = sda_in;
    if (done) done_cnt++;
    if (!reset_n) begin
      pull  = 1'b0;
      nbits = 0;
    end else if (prev_scl && m_scl && prev_sda && !m_sda) begin
      starts++;
      nbits  = 0;
      fbytes = 0;
    end else if (prev_scl && m_scl && !prev_sda && m_sda) begin
      stops++;
      nbits = 0;
    end else if (!prev_scl && m_scl) begin
      if (nbits < 8) begin
        cur = {cur[6:0], m_sda};
        nbits++;
        if (nbits == 8) begin
          seen.push_back(cur);
          fbytes++;
        end
      end else begin
        nbits = 9;
      end
    end else if (prev_scl && !m_scl) begin
      if (nbits == 8) begin
        pull = ((fbytes - 1) != nack_byte);
      end else if (nbits == 9) begin
        pull  = 1'b0;
        nbits = 0;
      end
    end
    prev_scl = m_scl;
    prev_sda = m_sda;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    seen.delete();
    starts   = 0;
    stops    = 0;
    done_cnt = 0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk50);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic launch(input logic [15:0] d, input int nb);
    @(negedge clk50);
    clear_mon();
    nack_byte = nb;
    data  = d;
    start = 1'b1;
    acc   = cyc;
    @(negedge clk50);
    start = 1'b0;
    check("busy_after_accept", busy, 1);
    check("ack_err_cleared", ack_err, 0);
  endtask

  // reference: frame length in quarters follows directly from how many bytes were sent
  function automatic int exp_bytes(input int nb);
    return (nb < 3) ? nb + 1 : 3;
  endfunction

  task automatic check_bytes(input logic [15:0] d, input int n, input int frames);
    logic [7:0] exp_b[3];
    exp_b[0] = 8'h34;
    exp_b[1] = d[15:8];
    exp_b[2] = d[7:0];
    check("nbytes", seen.size(), n * frames);
    for (int i = 0; i < seen.size() && i < n * frames; i++) begin
      check($sformatf("byte%0d", i), seen[i], exp_b[i % n]);
    end
  endtask

  task automatic finish_frame(input logic [15:0] d, input int nb);
    bit ok;
    int n;
    n = exp_bytes(nb);
    wait_done(1000, ok);
    if (ok) begin
      check("latency", cyc - acc, (8 + 36 * n) * CLK_DIV + 1);
      check("ack_err", ack_err, (nb < 3) ? 1 : 0);
      check("busy_at_done", busy, 0);
    end
    repeat (4) @(negedge clk50);
    check("done_count", done_cnt, 1);
    check("starts", starts, 1);
    check("stops", stops, 1);
    check_bytes(d, n, 1);
  endtask

  initial begin
    bit ok;
    logic [15:0] d;
    int nb;

    reset_n = 1'b0;
    start   = 1'b1;
    data    = 16'hA5A5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk50);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ack_err", ack_err, 0);
      check("rst_scl_oe", scl_oe, 0);
      check("rst_sda_oe", sda_oe, 0);
    end
    reset_n = 1'b1;
    start   = 1'b0;
    repeat (5) @(negedge clk50);
    check("idle_after_rst", busy, 0);
    check("no_start_in_rst", starts, 0);

    // full ACKed write
    launch(16'h0C00, 3);
    finish_frame(16'h0C00, 3);

    // address NACK, ack_err holds until next acceptance
    launch(16'h0C00, 0);
    finish_frame(16'h0C00, 0);
    repeat (20) @(negedge clk50);
    check("ack_err_hold", ack_err, 1);

    // NACK on the second byte
    launch(16'h5A3C, 1);
    finish_frame(16'h5A3C, 1);

    // start and data changes while busy are ignored
    launch(16'h1E00, 3);
    repeat (49) @(negedge clk50);
    start = 1'b1;
    data  = 16'hFFFF;
    @(negedge clk50);
    start = 1'b0;
    finish_frame(16'h1E00, 3);

    // reset in the middle of a frame
    launch(16'h7E81, 3);
    repeat (99) @(negedge clk50);
    reset_n = 1'b0;
    @(negedge clk50);
    check("midrst_scl_oe", scl_oe, 0);
    check("midrst_sda_oe", sda_oe, 0);
    check("midrst_busy", busy, 0);
    reset_n = 1'b1;
    repeat (300) @(negedge clk50);
    check("midrst_no_done", done_cnt, 0);
    d = 16'($urandom);
    launch(d, 3);
    finish_frame(d, 3);

    // back-to-back with start held high
    @(negedge clk50);
    clear_mon();
    nack_byte = 3;
    data  = 16'h1201;
    start = 1'b1;
    acc   = cyc;
    wait_done(1000, ok);
    if (ok) check("b2b_lat1", cyc - acc, (8 + 36 * 3) * CLK_DIV + 1);
    @(negedge clk50);
    acc = cyc;
    check("b2b_gap_idle", busy, 0);
    @(negedge clk50);
    check("b2b_accept", busy, 1);
    start = 1'b0;
    wait_done(1000, ok);
    if (ok) check("b2b_lat2", cyc - acc, (8 + 36 * 3) * CLK_DIV + 1);
    repeat (4) @(negedge clk50);
    check("b2b_done_count", done_cnt, 2);
    check("b2b_starts", starts, 2);
    check("b2b_stops", stops, 2);
    check_bytes(16'h1201, 3, 2);

    // randomized frames with random NACK position
    for (int k = 0; k < 6; k++) begin
      d  = 16'($urandom);
      nb = int'($urandom_range(0, 3));
      launch(d, nb);
      finish_frame(d, nb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
